// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR latch driver: FSM state encoding, request op
// encoding and a width helper for the internal down-counters.
`timescale 1ns/100ps
package sr_latch_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_fb_sync.sv
// Feedback synchroniser: STAGES-deep flop chain bringing an asynchronous latch
// output into the clk domain. Clears to 0 on reset.
`timescale 1ns/100ps
module sr_fb_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_chain <= '0;
        else          r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked driver for a NAND SR latch. Converts set/clear requests into
// mutually exclusive active-low pulses, then watches synchronised q/q_bar
// feedback and reports completion or settle timeout.
// Optional statistics counters are built when SR_DRV_STATS_EN is defined;
// otherwise the stat ports are tied to 0.
//
//  state     | meaning
//  ST_IDLE   | ready for a request; illegal-state watch active
//  ST_PULSE  | s_n or r_n held low for PULSE_CYCLES cycles
//  ST_SETTLE | pulses released; waiting for feedback to match the target
`timescale 1ns/100ps
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int SETTLE_TIMEOUT = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    input  logic             i_req_op,
    output logic             o_req_ready,
    output logic             o_s_n,
    output logic             o_r_n,
    input  logic             i_q_in,
    input  logic             i_q_bar_in,
    output logic             o_resp_valid,
    output logic             o_resp_err,
    output logic             o_latch_q,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_set_cnt,
    output logic [CNT_W-1:0] o_clr_cnt,
    output logic [CNT_W-1:0] o_tmo_cnt
);

    localparam int TMR_MAX = (PULSE_CYCLES > SETTLE_TIMEOUT) ? PULSE_CYCLES - 1 : SETTLE_TIMEOUT - 1;
    localparam int TMR_W   = cnt_w(TMR_MAX);
    localparam int BLK_W   = cnt_w(SYNC_STAGES);

    state_t           r_state;
    logic             r_op;
    logic [TMR_W-1:0] r_tmr;
    logic [BLK_W-1:0] r_blank;
    logic [BLK_W-1:0] r_flush;
    logic             r_s_n;
    logic             r_r_n;
    logic             r_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_ill_pend;
    logic             r_illegal;

    logic w_q_sync;
    logic w_qb_sync;
    logic w_fb_match;
    logic w_accept;
    logic w_settle_ok;
    logic w_timeout;

    sr_fb_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_q_in),
        .o_q     (w_q_sync)
    );

    sr_fb_sync #(.STAGES(SYNC_STAGES)) u_sync_qb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_q_bar_in),
        .o_q     (w_qb_sync)
    );

    // Feedback is only trusted once SYNC_STAGES cycles have passed since the
    // pulse was released, so the sample reflects the latch holding on its own.
    assign w_fb_match  = (w_q_sync == r_op) && (w_qb_sync == ~r_op);
    assign w_accept    = (r_state == ST_IDLE) && r_ready && i_req_valid;
    assign w_settle_ok = (r_state == ST_SETTLE) && (r_blank == '0) && w_fb_match;
    assign w_timeout   = (r_state == ST_SETTLE) && !w_settle_ok && (r_tmr == '0);

    // Sequencing FSM with registered pulse, handshake and response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_CLR;
            r_tmr        <= '0;
            r_blank      <= '0;
            r_s_n        <= 1'b1;
            r_r_n        <= 1'b1;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_req_op;
                        r_ready <= 1'b0;
                        r_tmr   <= TMR_W'(PULSE_CYCLES - 1);
                        r_state <= ST_PULSE;
                        if (i_req_op == OP_SET) r_s_n <= 1'b0;
                        else                    r_r_n <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (r_tmr == '0) begin
                        r_s_n   <= 1'b1;
                        r_r_n   <= 1'b1;
                        r_tmr   <= TMR_W'(SETTLE_TIMEOUT - 1);
                        r_blank <= BLK_W'(SYNC_STAGES);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_blank != '0) r_blank <= r_blank - 1'b1;
                    if (w_settle_ok || w_timeout) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_timeout;
                        r_ready      <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: begin
                    r_s_n   <= 1'b1;
                    r_r_n   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky illegal flag: q == q_bar for two consecutive IDLE cycles. The
    // flush count skips the cycles where the synchronisers still hold reset 0s.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush    <= BLK_W'(SYNC_STAGES);
            r_ill_pend <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (r_flush != '0) begin
            r_flush    <= r_flush - 1'b1;
            r_ill_pend <= 1'b0;
        end else if ((r_state == ST_IDLE) && (w_q_sync == w_qb_sync)) begin
            r_ill_pend <= 1'b1;
            if (r_ill_pend) r_illegal <= 1'b1;
        end else begin
            r_ill_pend <= 1'b0;
        end
    end

`ifdef SR_DRV_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_set_cnt;
    logic [CNT_W-1:0] r_clr_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;

    // Saturating counts of accepted set/clear requests and timeouts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_set_cnt <= '0;
            r_clr_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_accept && (i_req_op == OP_SET) && (r_set_cnt != CNT_MAX)) r_set_cnt <= r_set_cnt + 1'b1;
            if (w_accept && (i_req_op == OP_CLR) && (r_clr_cnt != CNT_MAX)) r_clr_cnt <= r_clr_cnt + 1'b1;
            if (w_timeout && (r_tmo_cnt != CNT_MAX))                      r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign o_set_cnt = r_set_cnt;
    assign o_clr_cnt = r_clr_cnt;
    assign o_tmo_cnt = r_tmo_cnt;
`else
    assign o_set_cnt = '0;
    assign o_clr_cnt = '0;
    assign o_tmo_cnt = '0;
`endif

    assign o_req_ready  = r_ready;
    assign o_s_n        = r_s_n;
    assign o_r_n        = r_r_n;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_latch_q    = w_q_sync;
    assign o_illegal    = r_illegal;

endmodule
